// File: rtl/a_buffer_output_ctrl.sv
// a_buffer_output_ctrl: A-buffer output stage, captures PE-array results per channel/row/column and streams 25-column row words
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   initial_iteration                   1 overwrite, 0 accumulate into stored value
//   cnt_rst                             synchronous clear of write/read pointers
//   layer_width, kn_size_mode, com_type feature-map width, kernel mode, conv/depthwise select
//   wr_rd_mode, current_channel_NO      write period select and channel of data_in (0 = none)
//   rd_out_en                           read strobe
//   data_in / data_out                  25 lanes x FEATURE_WIDTH
module a_buffer_output_ctrl #(
  parameter int FEATURE_WIDTH = 16,
  parameter int BUFFER_NUM = 25,
  parameter int RAM_DEPTH = 80,
  parameter logic [1:0] KERNEL_SIZE_1_MODE = 2'd0,
  parameter logic [1:0] KERNEL_SIZE_3_MODE = 2'd1,
  parameter logic [1:0] KERNEL_SIZE_5_MODE = 2'd2,
  parameter logic [7:0] NORMAL_CONV_MODE = 8'h01,
  parameter logic [7:0] DW_CONV_MODE = 8'h02
) (
  input  logic clk,
  input  logic rst,
  input  logic initial_iteration,
  input  logic cnt_rst,
  input  logic [15:0] layer_width,
  input  logic [1:0] kn_size_mode,
  input  logic [7:0] com_type,
  input  logic wr_rd_mode,
  input  logic [4:0] current_channel_NO,
  input  logic rd_out_en,
  input  logic [FEATURE_WIDTH*BUFFER_NUM-1:0] data_in,
  output logic [FEATURE_WIDTH*BUFFER_NUM-1:0] data_out
);
  logic [FEATURE_WIDTH-1:0] mem [RAM_DEPTH][BUFFER_NUM];
  logic [2:0] row_p, rd_row, rows, inc;
  logic [15:0] col_p, grp_p, rd_cg, cg;
  logic [3:0] rd_ch, nch;
  logic dw, k3, pw, wr, rd, col_adv, grp_adv;
  logic we [BUFFER_NUM];
  logic [6:0] wa [BUFFER_NUM];
  logic [4:0] wl [BUFFER_NUM];
  logic [FEATURE_WIDTH-1:0] wd [BUFFER_NUM];
  logic [31:0] t_ch, t_row, t_col, t_a, ra;
  logic [FEATURE_WIDTH*BUFFER_NUM-1:0] rd_word;

  assign dw = com_type == DW_CONV_MODE;
  assign k3 = kn_size_mode == KERNEL_SIZE_3_MODE;
  assign pw = kn_size_mode == KERNEL_SIZE_1_MODE && com_type == NORMAL_CONV_MODE;
  assign rows = k3 ? 3'd4 : 3'd5;
  assign inc = k3 ? 3'd2 : kn_size_mode == KERNEL_SIZE_5_MODE ? 3'd1 : 3'd0;
  assign nch = dw ? 4'd4 : 4'd8;
  assign cg = 16'((32'(layer_width) + 32'd24) / 32'd25);
  assign wr = wr_rd_mode && current_channel_NO != 5'd0 && !cnt_rst;
  assign rd = !wr_rd_mode && rd_out_en && !cnt_rst;
  assign col_adv = wr && !pw && (dw || current_channel_NO == 5'd8);
  assign grp_adv = wr && pw && current_channel_NO == 5'd8;

  // Per-lane write target: every lane resolves to its own (ch,row,col), so targets never collide
  always_comb begin
    t_ch = '0;
    t_row = '0;
    t_col = '0;
    t_a = '0;
    for (int i = 0; i < BUFFER_NUM; i++) begin
      t_ch = dw ? 32'(i % 4) : 32'(current_channel_NO) - 32'd1;
      t_row = pw ? 32'(i / 5) : 32'(row_p) + (dw ? 32'(i / 4) : 32'(i));
      t_col = pw ? 32'(grp_p) * 32'd5 + 32'(i % 5) : 32'(col_p);
      t_a = (t_ch * 32'd5 + t_row) * 32'(cg) + t_col / 32'd25;
      we[i] = wr && t_col < 32'(layer_width) && t_a < 32'(RAM_DEPTH) && (pw || i < (dw ? 4 : 1) * (k3 ? 2 : 1));
      wa[i] = t_a[6:0];
      wl[i] = 5'(t_col % 32'd25);
      wd[i] = initial_iteration ? data_in[i*FEATURE_WIDTH +: FEATURE_WIDTH]
                                : mem[wa[i]][wl[i]] + data_in[i*FEATURE_WIDTH +: FEATURE_WIDTH];
    end
  end

  // Columns past the layer width read as zero even if the entry holds stale data
  always_comb begin
    ra = (32'(rd_ch) * 32'd5 + 32'(rd_row)) * 32'(cg) + 32'(rd_cg);
    rd_word = '0;
    for (int b = 0; b < BUFFER_NUM; b++)
      rd_word[b*FEATURE_WIDTH +: FEATURE_WIDTH] =
        (32'(rd_cg) * 32'd25 + 32'(b) < 32'(layer_width) && ra < 32'(RAM_DEPTH)) ? mem[ra[6:0]][b] : '0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < RAM_DEPTH; i++)
        for (int j = 0; j < BUFFER_NUM; j++)
          mem[i][j] <= '0;
    end else begin
      for (int i = 0; i < BUFFER_NUM; i++)
        if (we[i]) mem[wa[i]][wl[i]] <= wd[i];
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row_p <= '0;
      col_p <= '0;
      grp_p <= '0;
      rd_ch <= '0;
      rd_row <= '0;
      rd_cg <= '0;
      data_out <= '0;
    end else if (cnt_rst) begin
      row_p <= '0;
      col_p <= '0;
      grp_p <= '0;
      rd_ch <= '0;
      rd_row <= '0;
      rd_cg <= '0;
    end else begin
      if (col_adv) begin
        col_p <= col_p >= layer_width - 16'd1 ? '0 : col_p + 16'd1;
        if (col_p >= layer_width - 16'd1) row_p <= row_p + inc >= rows ? 3'd0 : row_p + inc;
      end
      if (grp_adv) grp_p <= grp_p >= (layer_width + 16'd4) / 16'd5 - 16'd1 ? '0 : grp_p + 16'd1;
      if (rd) begin
        data_out <= rd_word;
        rd_cg <= rd_cg >= cg - 16'd1 ? '0 : rd_cg + 16'd1;
        if (rd_cg >= cg - 16'd1) begin
          rd_row <= rd_row >= rows - 3'd1 ? '0 : rd_row + 3'd1;
          if (rd_row >= rows - 3'd1) rd_ch <= rd_ch >= nch - 4'd1 ? '0 : rd_ch + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_a_buffer_output_ctrl.sv
// tb_a_buffer_output_ctrl: directed vector table, hand sequences and randomized checks against a channel/row/column model
module tb_a_buffer_output_ctrl;
  localparam int W = 400;
  logic clk = 0, rst = 0, initial_iteration = 1, cnt_rst = 0, wr_rd_mode = 0, rd_out_en = 0;
  logic [15:0] layer_width = 16'd28;
  logic [1:0] kn_size_mode = 2'd2;
  logic [7:0] com_type = 8'h01;
  logic [4:0] current_channel_NO = 5'd0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  int errors = 0, checks = 0;
  logic [15:0] m [8][5][50];
  int mr, mc, mg;
  logic [W-1:0] words [80];

  typedef struct {logic [1:0] kn; logic [7:0] com; logic [15:0] width; int nwr; logic init; logic fresh; logic div8; int nrd;} scn_t;
  typedef struct {int scn; int word; int lane; logic [15:0] exp;} vec_t;
  scn_t scn [4];
  vec_t vec [26];

  a_buffer_output_ctrl dut (.clk(clk), .rst(rst), .initial_iteration(initial_iteration), .cnt_rst(cnt_rst),
    .layer_width(layer_width), .kn_size_mode(kn_size_mode), .com_type(com_type), .wr_rd_mode(wr_rd_mode),
    .current_channel_NO(current_channel_NO), .rd_out_en(rd_out_en), .data_in(data_in), .data_out(data_out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 5; r++)
        for (int k = 0; k < 50; k++)
          m[c][r][k] = '0;
    mr = 0; mc = 0; mg = 0;
  endtask

  task automatic put(input int ch, input int row, input int col, input logic [15:0] v, input logic init);
    if (col < int'(layer_width)) m[ch][row][col] = init ? v : m[ch][row][col] + v;
  endtask

  task automatic model_write(input logic [4:0] cn, input logic [W-1:0] d, input logic init);
    bit dw, k3, k1;
    int w, rows, inc;
    dw = com_type == 8'h02; k3 = kn_size_mode == 2'd1; k1 = kn_size_mode == 2'd0;
    w = int'(layer_width); rows = k3 ? 4 : 5; inc = k3 ? 2 : (k1 ? 0 : 1);
    if (cn == 0) return;
    if (k1 && !dw) begin
      for (int i = 0; i < 25; i++) put(int'(cn) - 1, i / 5, mg * 5 + i % 5, d[i*16 +: 16], init);
      if (cn == 8) mg = (mg == (w + 4) / 5 - 1) ? 0 : mg + 1;
    end else begin
      if (dw) for (int i = 0; i < (k3 ? 8 : 4); i++) put(i % 4, mr + i / 4, mc, d[i*16 +: 16], init);
      else begin
        put(int'(cn) - 1, mr, mc, d[15:0], init);
        if (k3) put(int'(cn) - 1, mr + 1, mc, d[31:16], init);
      end
      if (dw || cn == 8) begin
        if (mc == w - 1) begin
          mc = 0; mr += inc;
          if (mr >= rows) mr = 0;
        end else mc++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_word(input int r);
    int w, cgn, rows, ch, row, cg;
    logic [W-1:0] x;
    w = int'(layer_width); cgn = (w + 24) / 25; rows = kn_size_mode == 2'd1 ? 4 : 5;
    cg = r % cgn; row = (r / cgn) % rows; ch = r / (cgn * rows);
    x = '0;
    for (int b = 0; b < 25; b++)
      if (cg * 25 + b < w) x[b*16 +: 16] = m[ch][row][cg*25+b];
    return x;
  endfunction

  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic pulse_cnt();
    cnt_rst = 1;
    @(negedge clk);
    cnt_rst = 0;
    mr = 0; mc = 0; mg = 0;
  endtask

  task automatic write_one(input logic [4:0] cn, input logic [W-1:0] d, input logic init);
    current_channel_NO = cn; data_in = d; initial_iteration = init; wr_rd_mode = 1;
    @(negedge clk);
    current_channel_NO = 0;
    model_write(cn, d, init);
  endtask

  task automatic read_n(input int n);
    wr_rd_mode = 0;
    for (int r = 0; r < n; r++) begin
      rd_out_en = 1;
      @(negedge clk);
      rd_out_en = 0;
      words[r] = data_out;
    end
  endtask

  task automatic run_scn(input int idx);
    logic [15:0] v;
    if (scn[idx].fresh) do_reset();
    kn_size_mode = scn[idx].kn; com_type = scn[idx].com; layer_width = scn[idx].width;
    wr_rd_mode = 1;
    pulse_cnt();
    for (int k = 0; k < scn[idx].nwr; k++) begin
      v = 16'(scn[idx].div8 ? k / 8 : k);
      write_one(scn[idx].com == 8'h02 ? 5'd1 : 5'(k % 8 + 1), {25{v}}, scn[idx].init);
    end
    wr_rd_mode = 0;
    pulse_cnt();
    read_n(scn[idx].nrd);
    for (int r = 0; r < scn[idx].nrd; r++) chk($sformatf("scn%0d_word%0d", idx, r), words[r], model_word(r));
  endtask

  initial begin
    int cur, n, nwr, cgn;
    logic [W-1:0] d;
    logic [4:0] cn;
    model_clear();
    scn[0] = '{2'd2, 8'h01, 16'd28, 224, 1'b1, 1'b1, 1'b1, 2};
    scn[1] = '{2'd2, 8'h01, 16'd28, 224, 1'b0, 1'b0, 1'b1, 2};
    scn[2] = '{2'd0, 8'h01, 16'd28, 48, 1'b1, 1'b1, 1'b0, 2};
    scn[3] = '{2'd1, 8'h02, 16'd28, 56, 1'b1, 1'b1, 1'b0, 32};
    vec = '{'{0, 0, 0, 16'd0}, '{0, 0, 5, 16'd5}, '{0, 0, 24, 16'd24}, '{0, 1, 0, 16'd25},
            '{0, 1, 2, 16'd27}, '{0, 1, 3, 16'd0}, '{0, 1, 24, 16'd0},
            '{1, 0, 0, 16'd0}, '{1, 0, 24, 16'd48}, '{1, 1, 2, 16'd54}, '{1, 1, 3, 16'd0}, '{1, 0, 7, 16'd14},
            '{2, 0, 0, 16'd0}, '{2, 0, 4, 16'd0}, '{2, 0, 5, 16'd8}, '{2, 0, 24, 16'd32},
            '{2, 1, 0, 16'd40}, '{2, 1, 2, 16'd40}, '{2, 1, 3, 16'd0},
            '{3, 0, 7, 16'd7}, '{3, 2, 24, 16'd24}, '{3, 1, 2, 16'd27}, '{3, 1, 3, 16'd0},
            '{3, 4, 0, 16'd28}, '{3, 8, 10, 16'd10}, '{3, 31, 2, 16'd55}};
    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, '0);
    rst = 1;
    @(negedge clk);
    cur = -1;
    for (int i = 0; i < 26; i++) begin
      if (vec[i].scn != cur) begin
        run_scn(vec[i].scn);
        cur = vec[i].scn;
      end
      chk($sformatf("vec%0d", i), W'(words[vec[i].word][vec[i].lane*16 +: 16]), W'(vec[i].exp));
    end
    repeat (3) @(negedge clk);
    chk("idle_hold", data_out, model_word(31));
    pulse_cnt();
    read_n(3);
    chk("pre_cnt_rst_word2", words[2], model_word(2));
    pulse_cnt();
    read_n(1);
    chk("cnt_rst_mid_read", words[0], model_word(0));
    wr_rd_mode = 1;
    pulse_cnt();
    write_one(5'd1, {25{16'h1234}}, 1'b1);
    current_channel_NO = 5'd1; data_in = {25{16'h4321}};
    @(posedge clk);
    #2 rst = 0;
    #1 chk("rst_mid_write_data_out", data_out, '0);
    current_channel_NO = 0;
    @(negedge clk);
    rst = 1;
    model_clear();
    pulse_cnt();
    read_n(32);
    for (int r = 0; r < 32; r++) chk($sformatf("after_rst_word%0d", r), words[r], '0);
    for (int it = 0; it < 6; it++) begin
      do_reset();
      com_type = $urandom_range(0, 1) ? 8'h02 : 8'h01;
      kn_size_mode = 2'(com_type == 8'h02 ? $urandom_range(1, 2) : $urandom_range(0, 2));
      layer_width = 16'($urandom_range(1, 50));
      wr_rd_mode = 1;
      pulse_cnt();
      nwr = $urandom_range(20, 200);
      for (int k = 0; k < nwr; k++) begin
        for (int i = 0; i < 25; i++) d[i*16 +: 16] = 16'($urandom);
        cn = 5'($urandom_range(0, 8));
        write_one(cn, d, $urandom_range(0, 3) != 0);
      end
      wr_rd_mode = 0;
      pulse_cnt();
      cgn = (int'(layer_width) + 24) / 25;
      n = (com_type == 8'h02 ? 4 : 8) * (kn_size_mode == 2'd1 ? 4 : 5) * cgn;
      read_n(n);
      for (int r = 0; r < n; r++) chk($sformatf("rand%0d_word%0d", it, r), words[r], model_word(r));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
